prog_clk_divider: RTL and testbench
===================================

Name: prog_clk_divider

Overview:
- Multi-channel, runtime-programmable clock divider. Successor to the fixed-DIV single-output divider.
- Each channel produces either a one-cycle tick or a near-50% square wave at clk/D. D is loaded per channel through a valid/ready config port.
- Divisor changes are glitch-free, applied at the period boundary. A global sync input realigns all channels.
- Drives the ultrasonic transducer timing and slow housekeeping ticks from the single system clock.

Parameters:
- NUM_CH, 4: number of independent channels (1..16).
- WIDTH, 16: divisor/counter width in bits.
- RESET_DIV, 2: divisor loaded into every channel at reset (0 to 2^WIDTH-1).
- RESET_MODE, 0: mode at reset. 0 = tick, 1 = square.
- CH_W (localparam): max(1, $clog2(NUM_CH)).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- sync  in  1  restart all channel counters in phase.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accepted when high with cfg_valid.
- cfg_ch  in  CH_W  target channel.
- cfg_div  in  WIDTH  new divisor D.
- cfg_mode  in  1  new mode.
- cfg_immediate  in  1  1 = apply next cycle and restart counter; 0 = apply at period boundary.
- div_out  out  NUM_CH  per-channel tick/square output, registered.
- pending  out  NUM_CH  per-channel flag: an update is queued, not yet applied.

Behaviour:
- Reset (rst low, async):
  - All counters 0, D = RESET_DIV, mode = RESET_MODE.
  - div_out = 0, pending = 0, cfg_ready = 1.
  - The counter starts on the first rising edge after rst rises.
- Per channel, cycle k after start:
  - cnt = k mod D, counting 0..D-1 then wrapping to 0.
- Outputs are flop outputs aligned with cnt, with no combinational decode on the pins.
  - Tick mode: div_out high for exactly one cycle when cnt == D-1. First tick is in cycle D-1 after start; period is D.
  - Square mode, D >= 2: div_out high while cnt < D/2 (integer division), low otherwise. Odd D gives high floor(D/2), low ceil(D/2).
  - Edges occur only at cnt transitions, so there are no glitches.
- Boundary divisors:
  - D = 0: channel disabled, cnt held 0, div_out held 0.
  - D = 1, tick mode: div_out constantly 1.
  - D = 1, square mode: div_out held 0.
- Config handshake:
  - cfg_ready = ~pending[cfg_ch] (combinational).
  - Transfer occurs when cfg_valid && cfg_ready. The request is latched into that channel's shadow {div, mode} and pending is set on the next edge.
  - cfg_ch >= NUM_CH: cfg_ready = 1, the request is accepted and discarded, and no state changes.
- Applying a deferred update (cfg_immediate = 0):
  - Applied on the edge where cnt == D-1 (or D <= 1): the next cycle has cnt = 0 with the new D/mode, and pending clears.
  - A disabled channel (D = 0) applies on the next edge.
- Immediate update (cfg_immediate = 1):
  - Shadow is bypassed and pending never sets.
  - Next cycle: new D/mode, cnt = 0, div_out = 0.
- Sync:
  - sync high on an edge: every channel's cnt goes to 0 and div_out to 0 next cycle.
  - Any queued pending update is applied at the same edge and pending clears.
  - Sync held high keeps counters at 0.
- Simultaneous events:
  - Sync plus an accepted deferred cfg to the same channel: the new cfg is applied immediately, treated as immediate.
  - Wrap plus an accepted cfg: impossible, because cfg_ready is low while pending; if pending is low, a cfg accepted in the wrap cycle is queued for the next boundary.
- Arithmetic:
  - Counter is WIDTH bits unsigned.
  - D = 2^WIDTH-1 is the maximum period, with no overflow.
  - D/2 is a right shift.
- Reset mid-operation: all state returns to reset values asynchronously, and pending updates are lost.

Test Plan:
1. Reset defaults (RESET_DIV = 2, tick): release rst, run 10 cycles -> every channel ticks in cycles 1, 3, 5, 7, 9; pending = 0.
2. Square modes: ch0 immediate D = 5 mode 1, ch1 immediate D = 4 mode 1 -> ch0 high 2 cycles / low 3; ch1 high 2 / low 2; period checked over 50 cycles.
3. Deferred update: ch2 running D = 500 tick, load D = 3 at cnt = 100 -> pending[2] = 1 and cfg_ready to ch2 = 0 until the cycle-499 tick; then ticks every 3 cycles; no short period.
4. Disable and D = 1: ch3 immediate D = 0 -> div_out[3] = 0 for 20 cycles; then D = 1 tick -> constant 1; D = 1 square -> constant 0.
5. Sync alignment: channels with D = 3, 7, 10, sync pulse at arbitrary cycle -> all counters 0 next cycle; ticks after sync at cycles 2, 6, 9; a queued pending on ch1 is applied at sync.
6. Async reset mid-run: assert rst between edges with pending set -> div_out, pending cleared immediately; D restored to RESET_DIV.

Source files
------------

// File: rtl/prog_clk_divider.sv
// rtl/prog_clk_divider.sv - multi-channel runtime-programmable clock divider
//
// Each channel counts 0..D-1 and drives a registered tick (cnt == D-1) or a
// near-50% square wave (cnt < D/2). New divisors are loaded through a
// valid/ready config port and take effect either immediately (counter
// restart) or at the channel's next period boundary via a one-deep shadow.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   sync          restart every channel counter in phase
//   cfg_valid     config request
//   cfg_ready     request accepted when high with cfg_valid
//   cfg_ch        target channel (out-of-range requests are swallowed)
//   cfg_div       new divisor D (0 disables the channel)
//   cfg_mode      new mode: 0 tick, 1 square
//   cfg_immediate 1 apply next cycle with restart, 0 apply at period boundary
//   div_out       per-channel registered tick/square output
//   pending       per-channel flag: a deferred update is queued
module prog_clk_divider #(
  parameter int NUM_CH     = 4,
  parameter int WIDTH      = 16,
  parameter int RESET_DIV  = 2,
  parameter int RESET_MODE = 0,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [WIDTH-1:0]  cfg_div,
  input  logic              cfg_mode,
  input  logic              cfg_immediate,
  output logic [NUM_CH-1:0] div_out,
  output logic [NUM_CH-1:0] pending
);

  // A channel with a queued update refuses further requests until it applies;
  // channel numbers beyond NUM_CH are always ready so they drain harmlessly.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = ~pending[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, div_q, sh_div_q;
    logic [WIDTH-1:0] cnt_d, div_d;
    logic             mode_q, sh_mode_q, pend_q, out_q;
    logic             mode_d, out_d;
    logic             accept, boundary, force_zero;

    assign accept   = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));
    // D of 0 or 1 has no interior counts, so every edge is a period boundary.
    assign boundary = (div_q <= WIDTH'(1)) || (cnt_q == div_q - WIDTH'(1));
    // A restart always begins with the output low, whatever the new decode says.
    assign force_zero = sync || (accept && cfg_immediate);

    always_comb begin
      div_d  = div_q;
      mode_d = mode_q;
      cnt_d  = cnt_q + WIDTH'(1);
      if (accept && (cfg_immediate || sync)) begin
        // A request arriving with sync is treated as immediate.
        div_d  = cfg_div;
        mode_d = cfg_mode;
        cnt_d  = '0;
      end else if (sync || boundary) begin
        cnt_d = '0;
        if (pend_q) begin
          div_d  = sh_div_q;
          mode_d = sh_mode_q;
        end
      end
    end

    // Decode on the next-state values so the flop output lines up with cnt.
    always_comb begin
      out_d = 1'b0;
      if (!force_zero && (div_d != '0)) begin
        if (!mode_d) out_d = (cnt_d == div_d - WIDTH'(1));
        else         out_d = (cnt_d < (div_d >> 1));
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q     <= '0;
        div_q     <= WIDTH'(RESET_DIV);
        mode_q    <= (RESET_MODE != 0);
        sh_div_q  <= '0;
        sh_mode_q <= 1'b0;
        pend_q    <= 1'b0;
        out_q     <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        div_q  <= div_d;
        mode_q <= mode_d;
        out_q  <= out_d;
        if (accept && !cfg_immediate && !sync) begin
          // Only reachable with pend_q low, so nothing queued is overwritten;
          // a request taken in the wrap cycle waits for the following boundary.
          sh_div_q  <= cfg_div;
          sh_mode_q <= cfg_mode;
          pend_q    <= 1'b1;
        end else if (sync || boundary) begin
          pend_q <= 1'b0;
        end
      end
    end

    assign div_out[g] = out_q;
    assign pending[g] = pend_q;
  end

endmodule

// File: tb/tb_prog_clk_divider.sv
// tb/tb_prog_clk_divider.sv - directed scoreboard bench for prog_clk_divider
module tb_prog_clk_divider;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 16;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              sync;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [WIDTH-1:0]  cfg_div;
  logic              cfg_mode;
  logic              cfg_immediate;
  logic [NUM_CH-1:0] div_out;
  logic [NUM_CH-1:0] pending;

  prog_clk_divider #(
    .NUM_CH(NUM_CH), .WIDTH(WIDTH), .RESET_DIV(2), .RESET_MODE(0)
  ) dut (
    .clk(clk), .rst(rst), .sync(sync),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_mode(cfg_mode), .cfg_immediate(cfg_immediate),
    .div_out(div_out), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    ch;
    logic  val;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int ch, input logic val);
    exp_t e;
    e.tag = tag;
    e.ch  = ch;
    e.val = val;
    exp_q.push_back(e);
  endtask

  // Advance one edge, sample 1 time unit later, and drain the scoreboard.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.tag, 32'(div_out[e.ch]), 32'(e.val));
    end
  endtask

  task automatic cfg(input int ch, input int d, input logic mode, input logic imm);
    cfg_valid     = 1'b1;
    cfg_ch        = CH_W'(ch);
    cfg_div       = WIDTH'(d);
    cfg_mode      = mode;
    cfg_immediate = imm;
  endtask

  initial begin
    int k0, k1, k;
    rst = 1'b0; sync = 1'b0; cfg_valid = 1'b0; cfg_ch = '0;
    cfg_div = '0; cfg_mode = 1'b0; cfg_immediate = 1'b0;

    // 1: reset defaults, D = 2 tick on every channel
    repeat (2) @(posedge clk);
    #1;
    chk("rst_div_out", 32'(div_out), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'h1);
    rst = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      for (int ch = 0; ch < NUM_CH; ch++) push_exp("t1_tick", ch, (c % 2) == 1);
      step();
      chk("t1_pending", 32'(pending), 32'h0);
    end

    // 2: square waves, ch0 D=5, ch1 D=4, both immediate
    cfg(0, 5, 1'b1, 1'b1);
    k0 = 0;
    push_exp("t2_ch0", 0, 1'b0);
    step();
    cfg(1, 4, 1'b1, 1'b1);
    k0 = 1; k1 = 0;
    push_exp("t2_ch0", 0, (k0 % 5) < 2);
    push_exp("t2_ch1", 1, 1'b0);
    step();
    cfg_valid = 1'b0;
    for (int c = 0; c < 50; c++) begin
      k0++; k1++;
      push_exp("t2_ch0", 0, (k0 % 5) < 2);
      push_exp("t2_ch1", 1, (k1 % 4) < 2);
      step();
    end

    // 3: deferred update on ch2 from D=500 to D=3 loaded at cnt 100
    cfg(2, 500, 1'b0, 1'b1);
    k = 0;
    push_exp("t3_start", 2, 1'b0);
    step();
    cfg_valid = 1'b0;
    while (k < 100) begin
      k++;
      push_exp("t3_pre", 2, 1'b0);
      step();
    end
    cfg(2, 3, 1'b0, 1'b0);
    #1;
    chk("t3_ready_before", 32'(cfg_ready), 32'h1);
    while (k < 530) begin
      k++;
      if (k < 500) push_exp("t3_old", 2, k == 499);
      else         push_exp("t3_new", 2, ((k - 500) % 3) == 2);
      step();
      cfg_valid = 1'b0;
      chk("t3_pending", 32'(pending[2]), 32'((k >= 101) && (k <= 499)));
      chk("t3_ready", 32'(cfg_ready), 32'(!((k >= 101) && (k <= 499))));
    end

    // 4: disable, then D = 1 tick, then D = 1 square on ch3
    cfg(3, 0, 1'b0, 1'b1);
    for (int c = 0; c < 20; c++) begin
      push_exp("t4_off", 3, 1'b0);
      step();
      cfg_valid = 1'b0;
    end
    cfg(3, 1, 1'b0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      push_exp("t4_d1_tick", 3, c != 0);
      step();
      cfg_valid = 1'b0;
    end
    cfg(3, 1, 1'b1, 1'b1);
    for (int c = 0; c < 10; c++) begin
      push_exp("t4_d1_sq", 3, 1'b0);
      step();
      cfg_valid = 1'b0;
      chk("t4_pending", 32'(pending[3]), 32'h0);
    end

    // 5: sync alignment with a queued update on ch1
    cfg(0, 3, 1'b0, 1'b1);  step();
    cfg(1, 20, 1'b0, 1'b1); step();
    cfg(2, 10, 1'b0, 1'b1); step();
    cfg_valid = 1'b0;
    repeat (4) step();
    cfg(1, 7, 1'b0, 1'b0);
    step();
    cfg_valid = 1'b0;
    repeat (2) step();
    chk("t5_queued", 32'(pending[1]), 32'h1);
    sync = 1'b1;
    for (int c = 0; c < 3; c++) begin
      for (int ch = 0; ch < NUM_CH; ch++) push_exp("t5_sync_hold", ch, 1'b0);
      step();
      chk("t5_pending_sync", 32'(pending), 32'h0);
    end
    sync = 1'b0;
    for (int j = 1; j <= 25; j++) begin
      push_exp("t5_ch0", 0, (j % 3) == 2);
      push_exp("t5_ch1", 1, (j % 7) == 6);
      push_exp("t5_ch2", 2, (j % 10) == 9);
      push_exp("t5_ch3", 3, 1'b0);
      step();
    end

    // 6: asynchronous reset between edges with an update queued
    cfg(2, 9, 1'b0, 1'b0);
    step();
    cfg_valid = 1'b0;
    chk("t6_queued", 32'(pending[2]), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_div_out", 32'(div_out), 32'h0);
    chk("t6_pending", 32'(pending), 32'h0);
    chk("t6_ready", 32'(cfg_ready), 32'h1);
    rst = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      for (int ch = 0; ch < NUM_CH; ch++) push_exp("t6_tick", ch, (c % 2) == 1);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
